rf_wb_arbiter: RTL and testbench

- Writeback-side initiator for the 32x32 register file write port (reg_write/waddr/wdata).
- Merges two result sources onto the single write port:
  - ALU results: in-order, high priority.
  - Load-unit results: out-of-band, buffered in a small FIFO.
- Applies anti-starvation to the FIFO, suppresses writes to r0, and exports read-hazard flags for the decode-stage operand reads.

---
 rtl/rf_wb_pkg.sv | 15 +
 rtl/rf_wb_fifo.sv | 81 ++++++++
 rtl/rf_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_FIFO} gnt_sel_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-result FIFO; exposes every slot's valid/addr for the hazard compare.
// With RF_WB_FWD_EN defined it also exports slot data and the head pointer.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [RF_AW-1:0]           i_addr,
  input  logic [RF_DW-1:0]           i_data,
  input  logic                       i_pop,
  output logic [RF_AW-1:0]           o_head_addr,
  output logic [RF_DW-1:0]           o_head_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_cnt,
  output logic [DEPTH-1:0]           o_ent_valid,
`ifdef RF_WB_FWD_EN
  output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
  output logic [DEPTH*RF_DW-1:0]     o_ent_data,
`endif
  output logic [DEPTH*RF_AW-1:0]     o_ent_addr
);

  localparam int PW = $clog2(DEPTH);

  rf_wr_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  // A full FIFO refuses the push even when the head is popped in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: i_addr, data: i_data};
  end

  assign o_head_addr = r_mem[r_rd_ptr].addr;
  assign o_head_data = r_mem[r_rd_ptr].data;

`ifdef RF_WB_FWD_EN
  assign o_rd_ptr = r_rd_ptr;
`endif

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PW-1:0] w_age;
    assign w_age           = PW'(gi) - r_rd_ptr;
    assign o_ent_valid[gi] = ({1'b0, w_age} < r_cnt);
    assign o_ent_addr[gi*RF_AW +: RF_AW] = r_mem[gi].addr;
`ifdef RF_WB_FWD_EN
    assign o_ent_data[gi*RF_DW +: RF_DW] = r_mem[gi].data;
`endif
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: ALU results (priority) and buffered load results share one
// register-file write port. RF_WB_FWD_EN adds forwarding outputs and ties hz1/hz2 low.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int AW       = RF_AW,
  parameter int DW       = RF_DW
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_waddr,
  input  logic [DW-1:0]          alu_wdata,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_waddr,
  input  logic [DW-1:0]          mem_wdata,
  output logic                   reg_write,
  output logic [AW-1:0]          waddr,
  output logic [DW-1:0]          wdata,
  input  logic                   re1,
  input  logic [AW-1:0]          raddr1,
  input  logic                   re2,
  input  logic [AW-1:0]          raddr2,
  output logic                   hz1,
  output logic                   hz2,
`ifdef RF_WB_FWD_EN
  output logic                   fwd1_valid,
  output logic [DW-1:0]          fwd1_data,
  output logic                   fwd2_valid,
  output logic [DW-1:0]          fwd2_data,
`endif
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0]       r_wait_cnt;
  logic                r_reg_write;
  logic [AW-1:0]       r_waddr;
  logic [DW-1:0]       r_wdata;

  gnt_sel_t            w_gnt;
  logic                w_alu_ready;
  logic                w_force;
  logic                w_full;
  logic                w_empty;
  logic [AW-1:0]       w_head_addr;
  logic [DW-1:0]       w_head_data;
  logic [AW-1:0]       w_gnt_addr;
  logic [DW-1:0]       w_gnt_data;
  logic [DEPTH-1:0]    w_ent_valid;
  logic [DEPTH*AW-1:0] w_ent_addr;
  logic [DEPTH-1:0]    w_m1;
  logic [DEPTH-1:0]    w_m2;
  logic                w_hz1_cond;
  logic                w_hz2_cond;
`ifdef RF_WB_FWD_EN
  logic [PW-1:0]       w_rd_ptr;
  logic [DEPTH*DW-1:0] w_ent_data;
`endif

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (mem_valid),
    .i_addr      (mem_waddr),
    .i_data      (mem_wdata),
    .i_pop       (w_gnt == GNT_FIFO),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_cnt       (fifo_cnt),
    .o_ent_valid (w_ent_valid),
`ifdef RF_WB_FWD_EN
    .o_rd_ptr    (w_rd_ptr),
    .o_ent_data  (w_ent_data),
`endif
    .o_ent_addr  (w_ent_addr)
  );

  assign mem_ready = !w_full;
  assign w_force   = (r_wait_cnt == WW'(MAX_WAIT)) && !w_empty;

  always_comb begin
    w_gnt       = GNT_NONE;
    w_alu_ready = 1'b1;
    if (w_force) begin
      w_gnt       = GNT_FIFO;
      w_alu_ready = 1'b0;
    end else if (alu_valid) begin
      w_gnt = GNT_ALU;
    end else if (!w_empty) begin
      w_gnt = GNT_FIFO;
    end
  end

  assign alu_ready  = w_alu_ready;
  assign w_gnt_addr = (w_gnt == GNT_ALU) ? alu_waddr : w_head_addr;
  assign w_gnt_data = (w_gnt == GNT_ALU) ? alu_wdata : w_head_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait_cnt  <= '0;
      r_reg_write <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      if (w_gnt == GNT_FIFO || w_empty)
        r_wait_cnt <= '0;
      else if (w_gnt == GNT_ALU && r_wait_cnt != WW'(MAX_WAIT))
        r_wait_cnt <= r_wait_cnt + 1'b1;

      // Writes to r0 still consume the grant but never reach the register file.
      if (w_gnt != GNT_NONE) begin
        r_reg_write <= (w_gnt_addr != RF_ZERO);
        r_waddr     <= w_gnt_addr;
        r_wdata     <= w_gnt_data;
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  assign reg_write = r_reg_write;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_m1[gi] = w_ent_valid[gi] && (w_ent_addr[gi*AW +: AW] == raddr1);
    assign w_m2[gi] = w_ent_valid[gi] && (w_ent_addr[gi*AW +: AW] == raddr2);
  end

  assign w_hz1_cond = re1 && (raddr1 != RF_ZERO) &&
                      ((|w_m1) || (r_reg_write && r_waddr == raddr1));
  assign w_hz2_cond = re2 && (raddr2 != RF_ZERO) &&
                      ((|w_m2) || (r_reg_write && r_waddr == raddr2));

`ifdef RF_WB_FWD_EN
  assign hz1        = 1'b0;
  assign hz2        = 1'b0;
  assign fwd1_valid = w_hz1_cond;
  assign fwd2_valid = w_hz2_cond;

  // Walk from the head (oldest) to the tail so the newest match wins.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx     = '0;
    fwd1_data = r_wdata;
    fwd2_data = r_wdata;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = w_rd_ptr + PW'(k);
      if (w_m1[v_idx]) fwd1_data = w_ent_data[v_idx*DW +: DW];
      if (w_m2[v_idx]) fwd2_data = w_ent_data[v_idx*DW +: DW];
    end
  end
`else
  assign hz1 = w_hz1_cond;
  assign hz2 = w_hz2_cond;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: per-source expected-write queues are
// filled when results are accepted and drained as reg_write pulses appear.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          reg_write;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1, re2;
  logic [AW-1:0] raddr1, raddr2;
  logic          hz1, hz2;
  logic          hz1_eff, hz2_eff;
  logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef RF_WB_FWD_EN
  logic          fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;
  assign hz1_eff = hz1 | fwd1_valid;
  assign hz2_eff = hz2 | fwd2_valid;
`else
  assign hz1_eff = hz1;
  assign hz2_eff = hz2;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(8), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .reg_write (reg_write),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .re2       (re2),
    .raddr2    (raddr2),
    .hz1       (hz1),
    .hz2       (hz2),
`ifdef RF_WB_FWD_EN
    .fwd1_valid(fwd1_valid),
    .fwd1_data (fwd1_data),
    .fwd2_valid(fwd2_valid),
    .fwd2_data (fwd2_data),
`endif
    .fifo_cnt  (fifo_cnt)
  );

  int checks = 0;
  int errors = 0;
  rf_wr_t alu_q[$];
  rf_wr_t mem_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    re1 = 1'b0;
    re2 = 1'b0;
  endtask

  // Every register-file write must match the head of one source queue.
  always @(negedge clk) begin
    if (mon_en && reg_write === 1'b1) begin
      rf_wr_t e;
      $display("WR r%0d <= %08h", waddr, wdata);
      if (alu_q.size() == 0 && mem_q.size() == 0) begin
        check("wr_unexp", reg_write, 1'b0);
      end else begin
        if (alu_q.size() != 0 && alu_q[0].addr == waddr) e = alu_q.pop_front();
        else if (mem_q.size() != 0)                       e = mem_q.pop_front();
        else                                              e = alu_q.pop_front();
        check("wr_addr", waddr, e.addr);
        check("wr_data", wdata, e.data);
      end
    end
  end

  initial begin
    int j;
    idle_inputs();
    alu_waddr = '0; alu_wdata = '0; mem_waddr = '0; mem_wdata = '0;
    raddr1 = '0; raddr2 = '0;
    rstn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_wr", reg_write, 1'b0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_mrdy", mem_ready, 1'b1);
    rstn = 1'b1;
    mon_en = 1'b1;
    tick();

    // ALU write with one-cycle latency
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h1234;
    @(negedge clk);
    check("alu_rdy", alu_ready, 1'b1);
    alu_q.push_back('{addr: 5'd3, data: 32'h1234});
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("alu_lat", reg_write, 1'b1);
    check("alu_waddr", waddr, 3);
    tick();

    // r0 suppression from both sources
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("r0_alu_rdy", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'h55;
    @(negedge clk);
    check("r0_alu_nowr", reg_write, 1'b0);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    check("r0_mem_cnt1", fifo_cnt, 1);
    tick();
    @(negedge clk);
    check("r0_mem_nowr", reg_write, 1'b0);
    check("r0_mem_cnt0", fifo_cnt, 0);
    tick();

    // Five loads against a busy ALU: fourth fills the FIFO, fifth is held
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_waddr = AW'(20 + i); alu_wdata = DW'(32'hA0 + i);
      mem_valid = 1'b1; mem_waddr = AW'(8 + i);  mem_wdata = DW'(32'hB0 + i);
      @(negedge clk);
      check("ld_alu_rdy", alu_ready, 1'b1);
      alu_q.push_back('{addr: AW'(20 + i), data: DW'(32'hA0 + i)});
      check("ld_mem_rdy", mem_ready, (i < 4));
      if (i < 4) mem_q.push_back('{addr: AW'(8 + i), data: DW'(32'hB0 + i)});
      if (i == 4) check("ld_cnt_full", fifo_cnt, 4);
      tick();
    end
    alu_valid = 1'b0;
    @(negedge clk);
    check("ld_full_pop", mem_ready, 1'b0);
    tick();
    @(negedge clk);
    check("ld_mrdy_back", mem_ready, 1'b1);
    mem_q.push_back('{addr: 5'd12, data: 32'hB4});
    tick();
    mem_valid = 1'b0;
    for (int t = 0; t < 20 && (fifo_cnt != 0 || mem_q.size() != 0); t++) tick();
    check("ld_drain", mem_q.size(), 0);
    tick();

    // Starvation: r9 waits behind exactly eight ALU grants
    j = 0;
    for (int k = 0; k <= 10; k++) begin
      alu_valid = 1'b1; alu_waddr = AW'(16 + (j % 8)); alu_wdata = DW'(32'hD00 + j);
      mem_valid = (k == 0); mem_waddr = 5'd9; mem_wdata = 32'hC9;
      @(negedge clk);
      check("stv_rdy", alu_ready, (k != 9));
      if (k == 0) mem_q.push_back('{addr: 5'd9, data: 32'hC9});
      if (k == 10) check("stv_wr_r9", waddr, 9);
      if (k != 9) begin
        alu_q.push_back('{addr: AW'(16 + (j % 8)), data: DW'(32'hD00 + j)});
        j++;
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // Hazard flags against FIFO entries and the output register
    alu_valid = 1'b1; alu_waddr = 5'd17; alu_wdata = 32'hE0;
    mem_valid = 1'b1; mem_waddr = 5'd5;  mem_wdata = 32'h55AA;
    @(negedge clk);
    alu_q.push_back('{addr: 5'd17, data: 32'hE0});
    mem_q.push_back('{addr: 5'd5, data: 32'h55AA});
    tick();
    mem_valid = 1'b0;
    alu_waddr = 5'd18; alu_wdata = 32'hE1;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
    @(negedge clk);
    check("hz1_fifo", hz1_eff, 1'b1);
    check("hz2_miss", hz2_eff, 1'b0);
`ifdef RF_WB_FWD_EN
    check("fwd1_data", fwd1_data, 32'h55AA);
`endif
    alu_q.push_back('{addr: 5'd18, data: 32'hE1});
    tick();
    alu_waddr = 5'd19; alu_wdata = 32'hE2;
    raddr1 = 5'd0; raddr2 = 5'd5;
    @(negedge clk);
    check("hz1_r0", hz1_eff, 1'b0);
    check("hz2_fifo", hz2_eff, 1'b1);
    alu_q.push_back('{addr: 5'd19, data: 32'hE2});
    tick();
    alu_valid = 1'b0;
    raddr1 = 5'd5; raddr2 = 5'd19;
    @(negedge clk);
    check("hz1_popping", hz1_eff, 1'b1);
    check("hz2_outreg", hz2_eff, 1'b1);
    tick();
    @(negedge clk);
    check("hz_wr5", waddr, 5);
    check("hz1_outreg", hz1_eff, 1'b1);
    check("hz2_clear", hz2_eff, 1'b0);
    tick();
    @(negedge clk);
    check("hz1_drop", hz1_eff, 1'b0);
    idle_inputs();
    tick();

    // Reset with three queued loads: none of them may ever be written
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_waddr = AW'(24 + i); alu_wdata = DW'(32'hF0 + i);
      mem_valid = 1'b1; mem_waddr = AW'(12 + i); mem_wdata = DW'(32'hC0 + i);
      @(negedge clk);
      alu_q.push_back('{addr: AW'(24 + i), data: DW'(32'hF0 + i)});
      tick();
    end
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    check("mrst_cnt3", fifo_cnt, 3);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("mrst_nowr", reg_write, 1'b0);
    check("mrst_cnt0", fifo_cnt, 0);
    check("mrst_mrdy", mem_ready, 1'b1);
    for (int t = 0; t < 8; t++) tick();

    check("sb_empty", alu_q.size() + mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
